// File: rtl/pipeline_hazard_ctrl_if.sv
// Control/status bundle between the hazard sequencer and the 5-stage pipeline datapath.
// The sequencer takes the slave side; the CPU top (or bench) takes the master side.
interface pipeline_hazard_ctrl_if #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
);
    logic              start_i;
    logic [REG_AW-1:0] id_rs1_i;
    logic [REG_AW-1:0] id_rs2_i;
    logic              idex_memrd_i;
    logic [REG_AW-1:0] idex_rd_i;
    logic              branch_tk_i;
    logic              mem_req_i;
    logic              mem_ready_i;
    logic              pc_write_o;
    logic              ifid_write_o;
    logic              ifid_flush_o;
    logic              idex_bubble_o;
    logic              pipe_hold_o;
    logic              err_o;
    logic [1:0]        state_o;
    logic [CNT_W-1:0]  stall_cnt_o;
    logic [CNT_W-1:0]  flush_cnt_o;
    logic [CNT_W-1:0]  wait_cnt_o;

    modport slave (
        input  start_i, id_rs1_i, id_rs2_i, idex_memrd_i, idex_rd_i,
               branch_tk_i, mem_req_i, mem_ready_i,
        output pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o, pipe_hold_o,
               err_o, state_o, stall_cnt_o, flush_cnt_o, wait_cnt_o
    );

    modport master (
        output start_i, id_rs1_i, id_rs2_i, idex_memrd_i, idex_rd_i,
               branch_tk_i, mem_req_i, mem_ready_i,
        input  pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o, pipe_hold_o,
               err_o, state_o, stall_cnt_o, flush_cnt_o, wait_cnt_o
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard sequencer: load-use stalls, branch flushes, data-memory waits, watchdog.
// Define HAZARD_PERF_CNT_EN to build the saturating stall/flush/wait counters.
module pipeline_hazard_ctrl #(
    parameter int REG_AW   = 5,
    parameter int CNT_W    = 32,
    parameter int MAX_WAIT = 16
) (
    input logic                   clk_i,
    input logic                   rst_i,
    pipeline_hazard_ctrl_if.slave hz
);
    localparam int WW = $clog2(MAX_WAIT) + 1;

    typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, MEM_WAIT = 2'b10, HALT = 2'b11} state_t;

    state_t            state_q, state_d;
    logic [WW-1:0]     wcnt_q, wcnt_d;
    logic              err_q, err_set;
    logic              pc_write, ifid_write, ifid_flush, idex_bubble, pipe_hold;
    logic              inc_stall, inc_flush, inc_wait;
    logic              memwait, loaduse;
    logic [REG_AW-1:0] rd;

    assign rd      = hz.idex_rd_i;
    assign memwait = hz.mem_req_i & ~hz.mem_ready_i;
    assign loaduse = hz.idex_memrd_i & (rd != '0) &
                     ((rd == hz.id_rs1_i) | (rd == hz.id_rs2_i));

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            wcnt_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            if (err_set) err_q <= 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        wcnt_d      = wcnt_q;
        err_set     = 1'b0;
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        pipe_hold   = 1'b0;
        inc_stall   = 1'b0;
        inc_flush   = 1'b0;
        inc_wait    = 1'b0;
        case (state_q)
            IDLE: begin
                idex_bubble = 1'b1;
                if (hz.start_i) state_d = RUN;
            end
            RUN: begin
                // A pending memory access must complete even if start_i drops.
                if (memwait) begin
                    pipe_hold = 1'b1;
                    state_d   = MEM_WAIT;
                    wcnt_d    = WW'(1);
                end else begin
                    if (loaduse) begin
                        idex_bubble = 1'b1;
                        inc_stall   = 1'b1;
                    end else begin
                        pc_write   = 1'b1;
                        ifid_write = 1'b1;
                        if (hz.branch_tk_i) begin
                            ifid_flush = 1'b1;
                            inc_flush  = 1'b1;
                        end
                    end
                    if (!hz.start_i) state_d = IDLE;
                end
            end
            MEM_WAIT: begin
                inc_wait = 1'b1;
                wcnt_d   = wcnt_q + 1'b1;
                if (hz.mem_ready_i) begin
                    pc_write   = 1'b1;
                    ifid_write = 1'b1;
                    state_d    = RUN;
                end else begin
                    pipe_hold = 1'b1;
                    if (wcnt_q == WW'(MAX_WAIT - 1)) begin
                        state_d = HALT;
                        err_set = 1'b1;
                    end
                end
            end
            default: begin
                idex_bubble = 1'b1;
                pipe_hold   = 1'b1;
            end
        endcase
    end

    assign hz.pc_write_o    = pc_write;
    assign hz.ifid_write_o  = ifid_write;
    assign hz.ifid_flush_o  = ifid_flush;
    assign hz.idex_bubble_o = idex_bubble;
    assign hz.pipe_hold_o   = pipe_hold;
    assign hz.err_o         = err_q;
    assign hz.state_o       = state_q;

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt, flush_cnt, wait_cnt;

    // Counters saturate so long runs never report a wrapped small value.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
            wait_cnt  <= '0;
        end else begin
            if (inc_stall && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
            if (inc_flush && flush_cnt != '1) flush_cnt <= flush_cnt + 1'b1;
            if (inc_wait  && wait_cnt  != '1) wait_cnt  <= wait_cnt  + 1'b1;
        end
    end

    assign hz.stall_cnt_o = stall_cnt;
    assign hz.flush_cnt_o = flush_cnt;
    assign hz.wait_cnt_o  = wait_cnt;
`else
    logic unused_inc;
    assign unused_inc     = inc_stall ^ inc_flush ^ inc_wait;
    assign hz.stall_cnt_o = {CNT_W{1'b0}};
    assign hz.flush_cnt_o = {CNT_W{1'b0}};
    assign hz.wait_cnt_o  = {CNT_W{1'b0}};
`endif
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: vector table for RUN decisions plus
// hand sequences for start-up, memory waits, watchdog halt and async reset.
module tb_pipeline_hazard_ctrl;
`ifdef HAZARD_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;

    pipeline_hazard_ctrl_if #(.REG_AW(5), .CNT_W(32)) hz ();

    pipeline_hazard_ctrl #(.REG_AW(5), .CNT_W(32), .MAX_WAIT(16)) dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .hz    (hz)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic       memrd;
        logic [4:0] rd, rs1, rs2;
        logic       br, req, rdy;
        logic [4:0] ctl;   // {pc_write, ifid_write, ifid_flush, idex_bubble, pipe_hold}
        logic [1:0] st;
    } vec_t;

    vec_t vt[13];

    function automatic vec_t mk(logic memrd, logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2,
                                logic br, logic req, logic rdy, logic [4:0] ctl, logic [1:0] st);
        vec_t v;
        v.memrd = memrd; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
        v.br = br; v.req = req; v.rdy = rdy; v.ctl = ctl; v.st = st;
        return v;
    endfunction

    function automatic logic [31:0] cexp(int n);
        return PERF ? 32'(n) : 32'd0;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(logic memrd, logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2,
                         logic br, logic req, logic rdy);
        hz.idex_memrd_i = memrd; hz.idex_rd_i = rd; hz.id_rs1_i = rs1; hz.id_rs2_i = rs2;
        hz.branch_tk_i = br; hz.mem_req_i = req; hz.mem_ready_i = rdy;
    endtask

    function automatic logic [31:0] ctl();
        return 32'({hz.pc_write_o, hz.ifid_write_o, hz.ifid_flush_o,
                    hz.idex_bubble_o, hz.pipe_hold_o});
    endfunction

    initial begin
        // RUN decision table; cumulative expectation after it: stall 3, flush 2, wait 1
        vt[0]  = mk(0, 0, 0, 0, 0, 0, 0, 5'b11000, 2'b01);
        vt[1]  = mk(1, 5, 1, 5, 0, 0, 0, 5'b00010, 2'b01);
        vt[2]  = mk(1, 0, 0, 0, 0, 0, 0, 5'b11000, 2'b01);
        vt[3]  = mk(1, 7, 7, 2, 0, 0, 0, 5'b00010, 2'b01);
        vt[4]  = mk(0, 7, 7, 7, 0, 0, 0, 5'b11000, 2'b01);
        vt[5]  = mk(1, 3, 4, 6, 0, 0, 0, 5'b11000, 2'b01);
        vt[6]  = mk(0, 0, 0, 0, 1, 0, 0, 5'b11100, 2'b01);
        vt[7]  = mk(1, 9, 9, 0, 1, 0, 0, 5'b00010, 2'b01);
        vt[8]  = mk(0, 9, 9, 0, 1, 0, 0, 5'b11100, 2'b01);
        vt[9]  = mk(0, 0, 0, 0, 0, 1, 1, 5'b11000, 2'b01);
        vt[10] = mk(1, 5, 5, 0, 1, 1, 0, 5'b00001, 2'b01);
        vt[11] = mk(0, 0, 0, 0, 0, 1, 1, 5'b11000, 2'b10);
        vt[12] = mk(0, 0, 0, 0, 0, 0, 0, 5'b11000, 2'b01);

        rst_n = 1'b0;
        hz.start_i = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("reset_state", 32'(hz.state_o), 32'd0);
        chk("reset_ctl", ctl(), 32'b00010);
        chk("reset_err", 32'(hz.err_o), 32'd0);
        chk("reset_cnt", hz.stall_cnt_o | hz.flush_cnt_o | hz.wait_cnt_o, 32'd0);
        #11 rst_n = 1'b1;

        // Start-up: start seen on cycle 2, PC advances in the following cycle
        tick();
        chk("idle_state", 32'(hz.state_o), 32'd0);
        hz.start_i = 1'b1;
        #1 chk("idle_pc_write", 32'(hz.pc_write_o), 32'd0);
        tick();
        chk("start_state", 32'(hz.state_o), 32'd1);
        chk("start_pc_write", 32'(hz.pc_write_o), 32'd1);

        for (int i = 0; i < 13; i++) begin
            drive(vt[i].memrd, vt[i].rd, vt[i].rs1, vt[i].rs2, vt[i].br, vt[i].req, vt[i].rdy);
            #1;
            chk($sformatf("vec%0d_ctl", i), ctl(), 32'(vt[i].ctl));
            chk($sformatf("vec%0d_state", i), 32'(hz.state_o), 32'(vt[i].st));
            tick();
        end
        chk("tbl_stall_cnt", hz.stall_cnt_o, cexp(3));
        chk("tbl_flush_cnt", hz.flush_cnt_o, cexp(2));
        chk("tbl_wait_cnt", hz.wait_cnt_o, cexp(1));

        // Memory busy for 3 cycles, ready on the 4th
        drive(0, 0, 0, 0, 0, 1, 0);
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("mw%0d_hold", c), ctl(), 32'b00001);
            chk($sformatf("mw%0d_state", c), 32'(hz.state_o), c == 0 ? 32'd1 : 32'd2);
            tick();
        end
        hz.mem_ready_i = 1'b1;
        #1;
        chk("mw_release_ctl", ctl(), 32'b11000);
        chk("mw_release_state", 32'(hz.state_o), 32'd2);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        #1 chk("mw_back_run", 32'(hz.state_o), 32'd1);
        chk("mw_wait_cnt", hz.wait_cnt_o, cexp(4));

        // start_i dropped in RUN: cycle completes, then IDLE
        hz.start_i = 1'b0;
        #1 chk("stop_last_cycle", ctl(), 32'b11000);
        tick();
        chk("stop_state", 32'(hz.state_o), 32'd0);
        chk("stop_ctl", ctl(), 32'b00010);
        hz.start_i = 1'b1;
        tick();
        chk("restart_state", 32'(hz.state_o), 32'd1);

        // Watchdog: 16 cycles without ready -> HALT
        drive(0, 0, 0, 0, 0, 1, 0);
        for (int c = 0; c < 16; c++) tick();
        chk("wd_state", 32'(hz.state_o), 32'd3);
        chk("wd_err", 32'(hz.err_o), 32'd1);
        chk("wd_ctl", ctl(), 32'b00011);
        chk("wd_wait_cnt", hz.wait_cnt_o, cexp(19));
        drive(0, 0, 0, 0, 0, 0, 1);
        for (int c = 0; c < 4; c++) begin
            hz.start_i = c[0];
            tick();
        end
        chk("halt_sticky_state", 32'(hz.state_o), 32'd3);
        chk("halt_sticky_err", 32'(hz.err_o), 32'd1);
        chk("halt_no_count", hz.wait_cnt_o, cexp(19));
        rst_n = 1'b0;
        #1;
        chk("halt_rst_state", 32'(hz.state_o), 32'd0);
        chk("halt_rst_err", 32'(hz.err_o), 32'd0);
        chk("halt_rst_cnt", hz.stall_cnt_o | hz.flush_cnt_o | hz.wait_cnt_o, 32'd0);

        // Reset asserted mid MEM_WAIT abandons the access at once
        #2 rst_n = 1'b1;
        hz.start_i = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 1, 0);
        tick();
        chk("mwrst_pre_state", 32'(hz.state_o), 32'd2);
        #1 rst_n = 1'b0;
        #1;
        chk("mwrst_state", 32'(hz.state_o), 32'd0);
        chk("mwrst_ctl", ctl(), 32'b00010);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
